reg_rename_file: RTL and testbench
==================================

# reg_rename_file

Architectural register file with per-register rename tags; the consumer end of the ROB commit broadcast. At dispatch it records which ROB tag will produce each destination register. When the ROB broadcasts a solved head entry (tag, value), it retires the value into the register and clears the rename if it is still current. Combinational operand ports give the reservation station and LSB either a ready value or the tag to wait on.

## Interface
- `TAG_W`, 4, ROB tag width; tag 0 means none/ready
- `NUM_TAGS`, 16, tag-map entries, 2^TAG_W
- `clk_in`  in  1  clock
- `rst_in`  in  1  reset, asynchronous, active-high
- `rdy_in`  in  1  global enable; low freezes all state
- `disp_valid`  in  1  instruction dispatched this cycle
- `disp_rd_idx`  in  5  destination register of dispatched instruction
- `disp_rob_tag`  in  TAG_W  ROB tag assigned (ROB push_rob_tag)
- `cdb_active`  in  1  ROB head solved and committing
- `cdb_tag`  in  TAG_W  committing tag
- `cdb_val`  in  32  committing value
- `predict_fail`  in  1  flush all renames
- `rs1_idx`, `rs2_idx`  in  5  operand register indices
- `rs1_val`, `rs2_val`  out  32  operand value, valid when tag out is 0
- `rs1_tag`, `rs2_tag`  out  TAG_W  producing tag, 0 = ready
- `commit_cnt`  out  32  number of register writes retired

## Operation
- State: `regs[0:31]` (32b), `reg_tag[0:31]` (TAG_W), `tag_map[0:NUM_TAGS-1]` = {valid, rd_idx}, `commit_cnt`.
- Dispatch (`disp_valid`, `rdy_in`, no `predict_fail`, `disp_rd_idx`≠0, `disp_rob_tag`≠0): `reg_tag[rd]`←tag; `tag_map[tag]`←{1, rd}. With rd=0 nothing is renamed and no map entry is written.
- Commit (`cdb_active`, `rdy_in`, `cdb_tag`≠0, `tag_map[cdb_tag].valid`): rd=map.rd_idx; `regs[rd]`←`cdb_val`; map entry invalidated; `commit_cnt`+1. `reg_tag[rd]` is cleared to 0 only if it equals `cdb_tag`, so a younger rename survives. A commit to an unmapped tag or to tag 0 is ignored and not counted.
- Same cycle, commit and dispatch to the same rd: the value is written and `reg_tag[rd]`←`disp_rob_tag`, so dispatch wins.
- Same cycle, dispatch reuses `cdb_tag`, which happens after ROB wrap: the map entry ends as the new {1, disp_rd}. The commit still uses the old mapping for its write.
- `predict_fail`: all `reg_tag`←0, all map valid←0, dispatch ignored. A simultaneous valid commit is still written and counted.
- x0: never written, `rs*_val`=0, `rs*_tag`=0 always.
- Operand read is combinational and reflects pre-edge state plus CDB bypass: if `reg_tag[idx]`≠0 and `cdb_active` and `cdb_tag`==`reg_tag[idx]`, output `cdb_val` with tag 0. Otherwise a nonzero tag outputs tag with val=`regs[idx]`, and a zero tag outputs val=`regs[idx]` with tag 0. The same-cycle dispatch does not affect reads.
- `rdy_in` low: no state changes; operand outputs still combinational.

## Timing
- Reset (async assert, released synchronously to `clk_in`): regs=0, tags=0, map invalid, `commit_cnt`=0. All outputs read 0 during reset.
- Dispatch visible on reads the cycle after the edge; commit visible in the same cycle via bypass, and from `regs` after the edge.
- Single-cycle update, no stalls, no backpressure; one dispatch and one commit per cycle.
- Reset asserted mid-operation discards in-flight renames immediately.

## Structure
- Shared package/macros: `ROB_TAG_W`, `TAG_NONE`=0, `NUM_REGS`=32, `REG_IDX_W`=5.
- Sub-module `tag_map`: NUM_TAGS-entry tag→rd table with write port (dispatch), lookup+invalidate port (commit), flush.
- Top holds `regs`, `reg_tag`, bypass muxes, and `commit_cnt`.

## Test plan
- Reset, then read x5 -> `rs1_val`=0, `rs1_tag`=0, `commit_cnt`=0.
- Dispatch rd=5 tag=3; next cycle read x5 -> tag=3. Then drive cdb tag=3 val=0xDEADBEEF: same cycle `rs1_val`=0xDEADBEEF, tag=0. Next cycle `regs[5]`=0xDEADBEEF, `commit_cnt`=1.
- Dispatch rd=7 tag=1, later rd=7 tag=2. Commit tag=1 val=0x11 -> x7 tag stays 2. Commit tag=2 val=0x22 -> x7=0x22, tag 0.
- Same cycle: commit tag=4 (mapped rd=9) val=0x44 and dispatch rd=9 tag=6 -> next cycle x9 val=0x44, tag=6.
- Renames on x1, x2, x3, then `predict_fail` with simultaneous commit tag of x1 val=0x55 -> all tags 0, x1=0x55. A later commit of x2's old tag is ignored and `commit_cnt` is unchanged.
- Dispatch rd=0 tag=5, then commit tag=5 val=0x99 -> x0 reads 0, `commit_cnt` unchanged. Hold `rdy_in`=0 while dispatching rd=4 -> x4 tag stays 0.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared definitions for the register rename file.
//   ROB_TAG_W  : ROB tag width; tag 0 means "no producer / ready"
//   TAG_NONE   : the "no producer" tag value
//   NUM_REGS   : architectural register count
//   REG_IDX_W  : architectural register index width
//   map_entry_t: one tag-map entry {valid, rd_idx}
package reg_rename_file_pkg;

   localparam int                   ROB_TAG_W = 4;
   localparam logic [ROB_TAG_W-1:0] TAG_NONE  = '0;
   localparam int                   NUM_REGS  = 32;
   localparam int                   REG_IDX_W = 5;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd_idx;
   } map_entry_t;

endpackage

// File: rtl/reg_rename_file_tag_map.sv
// tag_map: ROB tag -> destination register table.
//   clk_i, rst_i   : clock, async active-high reset
//   rdy_i          : global enable; low freezes the table
//   flush_i        : invalidate every entry (write port ignored)
//   wr_en_i        : dispatch write of {1, wr_rd_i} at wr_tag_i
//   wr_tag_i/wr_rd_i
//   lk_tag_i       : commit lookup tag
//   lk_inv_i       : invalidate the looked-up entry at the edge
//   lk_valid_o     : lookup hit (nonzero tag, entry valid)
//   lk_rd_o        : destination register of the looked-up entry
module tag_map
   import reg_rename_file_pkg::*;
#(
   parameter int TAG_W    = 4,
   parameter int NUM_TAGS = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rdy_i,
   input  logic                 flush_i,
   input  logic                 wr_en_i,
   input  logic [TAG_W-1:0]     wr_tag_i,
   input  logic [REG_IDX_W-1:0] wr_rd_i,
   input  logic [TAG_W-1:0]     lk_tag_i,
   input  logic                 lk_inv_i,
   output logic                 lk_valid_o,
   output logic [REG_IDX_W-1:0] lk_rd_o
);

   map_entry_t map_q [NUM_TAGS];
   map_entry_t map_d [NUM_TAGS];

   assign lk_valid_o = (lk_tag_i != '0) && map_q[lk_tag_i].valid;
   assign lk_rd_o    = map_q[lk_tag_i].rd_idx;

   // Write after invalidate: a dispatch reusing the committing tag (ROB wrap)
   // leaves the new mapping in place.
   always_comb begin
      for (int i = 0; i < NUM_TAGS; i++) map_d[i] = map_q[i];
      if (flush_i) begin
         for (int i = 0; i < NUM_TAGS; i++) map_d[i].valid = 1'b0;
      end else begin
         if (lk_inv_i) map_d[lk_tag_i].valid = 1'b0;
         if (wr_en_i)  map_d[wr_tag_i] = '{valid: 1'b1, rd_idx: wr_rd_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_TAGS; i++) map_q[i] <= '0;
      end else if (rdy_i) begin
         for (int i = 0; i < NUM_TAGS; i++) map_q[i] <= map_d[i];
      end
   end

endmodule

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural registers with per-register rename tags,
// retiring ROB commit broadcasts.
//   clk_in, rst_in          : clock, async active-high reset
//   rdy_in                  : global enable; low freezes all state
//   disp_valid/rd_idx/rob_tag : dispatch rename
//   cdb_active/tag/val      : ROB head commit broadcast
//   predict_fail            : flush all renames
//   rs1_idx, rs2_idx        : operand register indices
//   rs1_val/tag, rs2_val/tag: operand value, or producing tag (0 = ready)
//   commit_cnt              : number of retired register writes
module reg_rename_file
   import reg_rename_file_pkg::*;
#(
   parameter int TAG_W    = ROB_TAG_W,
   parameter int NUM_TAGS = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 disp_valid,
   input  logic [REG_IDX_W-1:0] disp_rd_idx,
   input  logic [TAG_W-1:0]     disp_rob_tag,
   input  logic                 cdb_active,
   input  logic [TAG_W-1:0]     cdb_tag,
   input  logic [31:0]          cdb_val,
   input  logic                 predict_fail,
   input  logic [REG_IDX_W-1:0] rs1_idx,
   input  logic [REG_IDX_W-1:0] rs2_idx,
   output logic [31:0]          rs1_val,
   output logic [TAG_W-1:0]     rs1_tag,
   output logic [31:0]          rs2_val,
   output logic [TAG_W-1:0]     rs2_tag,
   output logic [31:0]          commit_cnt
);

   logic [31:0]          regs_q    [NUM_REGS];
   logic [31:0]          regs_d    [NUM_REGS];
   logic [TAG_W-1:0]     reg_tag_q [NUM_REGS];
   logic [TAG_W-1:0]     reg_tag_d [NUM_REGS];
   logic [31:0]          commit_cnt_q;
   logic                 map_hit;
   logic [REG_IDX_W-1:0] commit_rd;
   logic                 commit_en;
   logic                 disp_en;

   assign commit_en = rdy_in && cdb_active && map_hit;
   assign disp_en   = rdy_in && disp_valid && !predict_fail &&
                      (disp_rd_idx != '0) && (disp_rob_tag != '0);

   tag_map #(.TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS)) u_tag_map (
      .clk_i      (clk_in),
      .rst_i      (rst_in),
      .rdy_i      (rdy_in),
      .flush_i    (predict_fail),
      .wr_en_i    (disp_en),
      .wr_tag_i   (disp_rob_tag),
      .wr_rd_i    (disp_rd_idx),
      .lk_tag_i   (cdb_tag),
      .lk_inv_i   (commit_en),
      .lk_valid_o (map_hit),
      .lk_rd_o    (commit_rd)
   );

   // Dispatch is applied after the commit clear so a same-cycle rename of the
   // committing register wins; a flush still lets the commit write land.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i]    = regs_q[i];
         reg_tag_d[i] = reg_tag_q[i];
      end
      if (commit_en && commit_rd != '0) begin
         regs_d[commit_rd] = cdb_val;
         if (reg_tag_q[commit_rd] == cdb_tag) reg_tag_d[commit_rd] = '0;
      end
      if (predict_fail) begin
         for (int i = 0; i < NUM_REGS; i++) reg_tag_d[i] = '0;
      end else if (disp_en) begin
         reg_tag_d[disp_rd_idx] = disp_rob_tag;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i]    <= '0;
            reg_tag_q[i] <= '0;
         end
         commit_cnt_q <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i]    <= regs_d[i];
            reg_tag_q[i] <= reg_tag_d[i];
         end
         if (commit_en) commit_cnt_q <= commit_cnt_q + 32'd1;
      end
   end

   assign commit_cnt = commit_cnt_q;

   // Operand read with CDB bypass; x0 is hardwired to ready zero.
   function automatic logic [32+TAG_W-1:0] read_port(input logic [REG_IDX_W-1:0] idx);
      logic [TAG_W-1:0] t;
      t = reg_tag_q[idx];
      if (idx == '0)                                 return '0;
      if (t != '0 && cdb_active && cdb_tag == t)     return {cdb_val, {TAG_W{1'b0}}};
      return {regs_q[idx], t};
   endfunction

   always_comb begin
      {rs1_val, rs1_tag} = read_port(rs1_idx);
      {rs2_val, rs2_tag} = read_port(rs2_idx);
   end

endmodule

// File: tb/tb_reg_rename_file.sv
module tb_reg_rename_file;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        disp_valid;
   logic [4:0]  disp_rd_idx;
   logic [3:0]  disp_rob_tag;
   logic        cdb_active;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        predict_fail;
   logic [4:0]  rs1_idx, rs2_idx;
   logic [31:0] rs1_val, rs2_val;
   logic [3:0]  rs1_tag, rs2_tag;
   logic [31:0] commit_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          port;
      logic [31:0] val;
      logic [3:0]  tag;
   } exp_t;

   exp_t  sb_q [$];
   string nm_q [$];

   reg_rename_file dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .disp_valid   (disp_valid),
      .disp_rd_idx  (disp_rd_idx),
      .disp_rob_tag (disp_rob_tag),
      .cdb_active   (cdb_active),
      .cdb_tag      (cdb_tag),
      .cdb_val      (cdb_val),
      .predict_fail (predict_fail),
      .rs1_idx      (rs1_idx),
      .rs2_idx      (rs2_idx),
      .rs1_val      (rs1_val),
      .rs1_tag      (rs1_tag),
      .rs2_val      (rs2_val),
      .rs2_tag      (rs2_tag),
      .commit_cnt   (commit_cnt)
   );

   always #5 clk_in = ~clk_in;

   // Inputs change at the falling edge; the design captures at the rising edge.
   task automatic next_cycle();
      @(negedge clk_in);
      disp_valid   = 1'b0;
      cdb_active   = 1'b0;
      predict_fail = 1'b0;
   endtask

   task automatic dispatch(input logic [4:0] rd, input logic [3:0] tag);
      disp_valid   = 1'b1;
      disp_rd_idx  = rd;
      disp_rob_tag = tag;
   endtask

   task automatic commit(input logic [3:0] tag, input logic [31:0] val);
      cdb_active = 1'b1;
      cdb_tag    = tag;
      cdb_val    = val;
   endtask

   // Select a read port index and queue the value/tag it must show.
   task automatic expect_rd(input string name, input int port, input logic [4:0] idx,
                            input logic [31:0] val, input logic [3:0] tag);
      exp_t e;
      if (port == 1) rs1_idx = idx;
      else           rs2_idx = idx;
      e.port = port;
      e.val  = val;
      e.tag  = tag;
      sb_q.push_back(e);
      nm_q.push_back(name);
   endtask

   task automatic check_reads();
      exp_t        e;
      string       n;
      logic [35:0] obs;
      #2;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         n   = nm_q.pop_front();
         obs = (e.port == 1) ? {rs1_val, rs1_tag} : {rs2_val, rs2_tag};
         tests++;
         assert (obs === {e.val, e.tag}) else begin
            fails++;
            $error("FAIL %s: observed val=%h tag=%0d, expected val=%h tag=%0d",
                   n, obs[35:4], obs[3:0], e.val, e.tag);
         end
      end
   endtask

   task automatic check_cnt(input string name, input logic [31:0] expv);
      tests++;
      assert (commit_cnt === expv) else begin
         fails++;
         $error("FAIL %s: observed commit_cnt=%0d, expected %0d", name, commit_cnt, expv);
      end
   endtask

   initial begin
      rst_in       = 1'b1;
      rdy_in       = 1'b1;
      disp_valid   = 1'b0;
      disp_rd_idx  = '0;
      disp_rob_tag = '0;
      cdb_active   = 1'b0;
      cdb_tag      = '0;
      cdb_val      = '0;
      predict_fail = 1'b0;
      rs1_idx      = '0;
      rs2_idx      = '0;

      // Reset state
      next_cycle();
      expect_rd("reset_x5", 1, 5'd5, 32'h0, 4'd0);
      check_reads();
      check_cnt("reset_cnt", 32'd0);
      next_cycle();
      rst_in = 1'b0;

      // Dispatch x5 <- tag 3, then commit with same-cycle bypass
      next_cycle();
      dispatch(5'd5, 4'd3);
      expect_rd("disp_same_cycle_x5", 1, 5'd5, 32'h0, 4'd0);
      check_reads();
      next_cycle();
      expect_rd("renamed_x5", 1, 5'd5, 32'h0, 4'd3);
      check_reads();
      next_cycle();
      commit(4'd3, 32'hDEADBEEF);
      expect_rd("bypass_x5", 1, 5'd5, 32'hDEADBEEF, 4'd0);
      check_reads();
      next_cycle();
      expect_rd("retired_x5", 1, 5'd5, 32'hDEADBEEF, 4'd0);
      check_reads();
      check_cnt("cnt_after_x5", 32'd1);

      // Younger rename on x7 survives the older commit
      dispatch(5'd7, 4'd1);
      next_cycle();
      dispatch(5'd7, 4'd2);
      next_cycle();
      commit(4'd1, 32'h11);
      expect_rd("old_commit_no_bypass_x7", 2, 5'd7, 32'h0, 4'd2);
      check_reads();
      next_cycle();
      expect_rd("young_rename_kept_x7", 2, 5'd7, 32'h11, 4'd2);
      check_reads();
      commit(4'd2, 32'h22);
      next_cycle();
      expect_rd("young_commit_x7", 2, 5'd7, 32'h22, 4'd0);
      check_reads();
      check_cnt("cnt_after_x7", 32'd3);

      // Same-cycle commit and dispatch on x9: dispatch wins the tag
      dispatch(5'd9, 4'd4);
      next_cycle();
      commit(4'd4, 32'h44);
      dispatch(5'd9, 4'd6);
      expect_rd("commit_disp_bypass_x9", 1, 5'd9, 32'h44, 4'd0);
      check_reads();
      next_cycle();
      expect_rd("commit_disp_x9", 1, 5'd9, 32'h44, 4'd6);
      check_reads();
      check_cnt("cnt_after_x9", 32'd4);

      // Flush with a simultaneous commit
      dispatch(5'd1, 4'd7);
      next_cycle();
      dispatch(5'd2, 4'd8);
      next_cycle();
      dispatch(5'd3, 4'd9);
      next_cycle();
      predict_fail = 1'b1;
      commit(4'd7, 32'h55);
      dispatch(5'd4, 4'd10);
      next_cycle();
      expect_rd("flush_commit_x1", 1, 5'd1, 32'h55, 4'd0);
      expect_rd("flush_x2", 2, 5'd2, 32'h0, 4'd0);
      check_reads();
      expect_rd("flush_x3", 1, 5'd3, 32'h0, 4'd0);
      expect_rd("flush_disp_ignored_x4", 2, 5'd4, 32'h0, 4'd0);
      check_reads();
      check_cnt("cnt_flush_commit", 32'd5);
      commit(4'd8, 32'h77);
      expect_rd("stale_commit_x2", 2, 5'd2, 32'h0, 4'd0);
      check_reads();
      next_cycle();
      expect_rd("stale_commit_after_x2", 2, 5'd2, 32'h0, 4'd0);
      check_reads();
      check_cnt("cnt_stale_commit", 32'd5);

      // x0 is never renamed or written
      dispatch(5'd0, 4'd5);
      next_cycle();
      commit(4'd5, 32'h99);
      expect_rd("x0_during_commit", 1, 5'd0, 32'h0, 4'd0);
      check_reads();
      next_cycle();
      expect_rd("x0_after_commit", 1, 5'd0, 32'h0, 4'd0);
      check_reads();
      check_cnt("cnt_x0_commit", 32'd5);

      // rdy_in low freezes state
      rdy_in = 1'b0;
      dispatch(5'd4, 4'd10);
      next_cycle();
      rdy_in = 1'b1;
      expect_rd("rdy_low_x4", 1, 5'd4, 32'h0, 4'd0);
      check_reads();
      check_cnt("cnt_rdy_low", 32'd5);

      // Dispatch reuses the committing tag (ROB wrap)
      dispatch(5'd13, 4'd12);
      next_cycle();
      commit(4'd12, 32'hAB);
      dispatch(5'd14, 4'd12);
      next_cycle();
      expect_rd("wrap_old_rd_x13", 1, 5'd13, 32'hAB, 4'd0);
      expect_rd("wrap_new_rd_x14", 2, 5'd14, 32'h0, 4'd12);
      check_reads();
      commit(4'd12, 32'hCD);
      next_cycle();
      expect_rd("wrap_x13_kept", 1, 5'd13, 32'hAB, 4'd0);
      expect_rd("wrap_x14_commit", 2, 5'd14, 32'hCD, 4'd0);
      check_reads();
      check_cnt("cnt_wrap", 32'd7);

      // Asynchronous reset mid-operation
      dispatch(5'd12, 4'd11);
      next_cycle();
      expect_rd("pre_reset_x12", 1, 5'd12, 32'h0, 4'd11);
      check_reads();
      rst_in = 1'b1;
      expect_rd("async_reset_x12", 1, 5'd12, 32'h0, 4'd0);
      expect_rd("async_reset_x5", 2, 5'd5, 32'h0, 4'd0);
      check_reads();
      check_cnt("async_reset_cnt", 32'd0);
      next_cycle();
      rst_in = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
